conv3x3_stream: RTL and testbench

//  Streaming 3x3 valid-mode convolution engine for one IMG_H x IMG_W signed frame, raster order.

---
 rtl/conv_pkg.sv | 14 +
 rtl/conv3x3_line_buf.sv | 28 ++
 rtl/conv3x3_stream.sv | 181 ++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 streaming convolution engine.
package conv_pkg;

  localparam int         KTAPS         = 9;
  localparam logic [3:0] CFG_ADDR_BIAS = 4'd9;

  // Default-width views of the coefficient set and the S1 product vector
  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;

  typedef logic signed [DEF_COEF_W-1:0]            coef_arr_t [KTAPS];
  typedef logic signed [DEF_DATA_W+DEF_COEF_W-1:0] prod_vec_t [KTAPS];

endpackage

// File: rtl/conv3x3_line_buf.sv
// Two-row circular line buffer indexed by column: row1 holds row-1, row2 holds row-2.
module conv3x3_line_buf #(
  parameter int IMG_W  = 28,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(IMG_W)-1:0]   col,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          row1_data,
  output logic [DATA_W-1:0]          row2_data
);

  logic [DATA_W-1:0] row1_mem_r [IMG_W];
  logic [DATA_W-1:0] row2_mem_r [IMG_W];

  assign row1_data = row1_mem_r[col];
  assign row2_data = row2_mem_r[col];

  // Column write on accept: new pixel enters row1, displaced row1 entry ages into row2
  always_ff @(posedge clk) begin
    if (we) begin
      row1_mem_r[col] <= din;
      row2_mem_r[col] <= row1_mem_r[col];
    end
  end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-mode convolution with runtime coefficients and valid/ready flow control.
// Define CONV3X3_RELU_EN to clamp negative results to zero in the final stage.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_addr,
  input  logic [ACC_W-1:0]         cfg_wdata,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = DATA_W + COEF_W;

  logic [CW-1:0]             col_r;
  logic [RW-1:0]             row_r;
  logic signed [COEF_W-1:0]  coef_r    [KTAPS];
  logic signed [ACC_W-1:0]   bias_r;
  logic signed [DATA_W-1:0]  win_r     [KTAPS];
  logic signed [DATA_W-1:0]  win_nxt_s [KTAPS];
  logic signed [PW-1:0]      prod_r    [KTAPS];
  logic signed [PW-1:0]      prod_s    [KTAPS];
  logic signed [ACC_W-1:0]   psum_r    [3];
  logic signed [ACC_W-1:0]   psum_s    [3];
  logic signed [ACC_W-1:0]   sum_s;
  logic signed [ACC_W-1:0]   res_s;
  logic signed [ACC_W-1:0]   out_data_r;
  logic signed [DATA_W-1:0]  lb_row1_s;
  logic signed [DATA_W-1:0]  lb_row2_s;
  logic s1_v_r, s1_last_r, s2_v_r, s2_last_r, out_valid_r, out_last_r;
  logic busy_r, frame_act_r;
  logic stall_s, en_s, accept_s, produce_s, col_end_s, row_end_s, frame_end_s;
  logic frame_act_nxt_s, s1_v_nxt_s, s2_v_nxt_s, out_valid_nxt_s, busy_nxt_s;

  assign in_ready  = en_s;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;

  conv3x3_line_buf #(
    .IMG_W  (IMG_W),
    .DATA_W (DATA_W)
  ) u_line_buf (
    .clk       (clk),
    .we        (accept_s),
    .col       (col_r),
    .din       (in_data),
    .row1_data (lb_row1_s),
    .row2_data (lb_row2_s)
  );

  // Handshake, frame position and next-state of the occupancy flags that form busy
  always_comb begin
    stall_s         = out_valid_r && !out_ready;
    en_s            = !stall_s;
    accept_s        = in_valid && en_s;
    col_end_s       = (col_r == CW'(IMG_W - 1));
    row_end_s       = (row_r == RW'(IMG_H - 1));
    frame_end_s     = col_end_s && row_end_s;
    produce_s       = accept_s && (row_r >= RW'(2)) && (col_r >= CW'(2));
    frame_act_nxt_s = accept_s ? !frame_end_s : frame_act_r;
    s1_v_nxt_s      = en_s ? produce_s   : s1_v_r;
    s2_v_nxt_s      = en_s ? s1_v_r      : s2_v_r;
    out_valid_nxt_s = en_s ? s2_v_r      : out_valid_r;
    busy_nxt_s      = frame_act_nxt_s || s1_v_nxt_s || s2_v_nxt_s || out_valid_nxt_s;
  end

  // Window after the shift (rightmost column = rows r-2, r-1, r) and its tap products
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt_s[r*3]     = win_r[r*3+1];
      win_nxt_s[r*3 + 1] = win_r[r*3+2];
    end
    win_nxt_s[2] = lb_row2_s;
    win_nxt_s[5] = lb_row1_s;
    win_nxt_s[8] = in_data;
    for (int i = 0; i < KTAPS; i++) begin
      prod_s[i] = PW'(win_nxt_s[i]) * PW'(coef_r[i]);
    end
  end

  // Adder tree: three row partial sums, then bias and optional clamp
  always_comb begin
    for (int g = 0; g < 3; g++) begin
      psum_s[g] = ACC_W'(prod_r[g*3]) + ACC_W'(prod_r[g*3+1]) + ACC_W'(prod_r[g*3+2]);
    end
    sum_s = bias_r + psum_r[0] + psum_r[1] + psum_r[2];
`ifdef CONV3X3_RELU_EN
    res_s = sum_s[ACC_W-1] ? {ACC_W{1'b0}} : sum_s;
`else
    res_s = sum_s;
`endif
  end

  // Coefficients, counters, window and the three pipeline stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_r       <= {CW{1'b0}};
      row_r       <= {RW{1'b0}};
      bias_r      <= {ACC_W{1'b0}};
      frame_act_r <= 1'b0;
      busy_r      <= 1'b0;
      s1_v_r      <= 1'b0;
      s1_last_r   <= 1'b0;
      s2_v_r      <= 1'b0;
      s2_last_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {ACC_W{1'b0}};
      for (int i = 0; i < KTAPS; i++) begin
        coef_r[i] <= {COEF_W{1'b0}};
        win_r[i]  <= {DATA_W{1'b0}};
        prod_r[i] <= {PW{1'b0}};
      end
      for (int g = 0; g < 3; g++) begin
        psum_r[g] <= {ACC_W{1'b0}};
      end
    end else begin
      // Writes land only between frames so a frame never sees mixed coefficients
      if (cfg_we && !busy_r) begin
        for (int i = 0; i < KTAPS; i++) begin
          if (cfg_addr == 4'(i)) begin
            coef_r[i] <= cfg_wdata[COEF_W-1:0];
          end
        end
        if (cfg_addr == CFG_ADDR_BIAS) begin
          bias_r <= cfg_wdata;
        end
      end

      if (accept_s) begin
        if (col_end_s) begin
          col_r <= {CW{1'b0}};
          row_r <= row_end_s ? {RW{1'b0}} : row_r + RW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end
        for (int i = 0; i < KTAPS; i++) begin
          win_r[i]  <= win_nxt_s[i];
          prod_r[i] <= prod_s[i];
        end
      end

      if (en_s) begin
        s1_last_r   <= accept_s && frame_end_s;
        s2_last_r   <= s1_last_r;
        out_last_r  <= s2_v_r && s2_last_r;
        for (int g = 0; g < 3; g++) begin
          psum_r[g] <= psum_s[g];
        end
        if (s2_v_r) begin
          out_data_r <= res_s;
        end
      end

      frame_act_r <= frame_act_nxt_s;
      s1_v_r      <= s1_v_nxt_s;
      s2_v_r      <= s2_v_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench: a 4x4 and a default 28x28 instance checked against a frame-level convolution model.
`timescale 1ns/1ps
module tb_conv3x3_stream;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               sel = 1'b0;
  logic               cfg_we = 1'b0;
  logic [3:0]         cfg_addr = 4'd0;
  logic [31:0]        cfg_wdata = 32'd0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = 16'sd0;
  logic               out_ready = 1'b1;

  logic s_busy, s_in_ready, s_out_valid, s_out_last;
  logic b_busy, b_in_ready, b_out_valid, b_out_last;
  logic signed [31:0] s_out_data, b_out_data;
  logic o_busy, o_in_ready, o_out_valid, o_out_last;
  logic signed [31:0] o_out_data;

  int mk [9];
  int mbias;
  int pix [784];
  int exp_data [$];
  bit exp_last [$];
  int got_data [$];
  bit got_last [$];
  int n_vec = 0;
  int n_err = 0;
  int stall_lo = 0;

  always #5 clk = ~clk;

  assign o_busy      = sel ? b_busy      : s_busy;
  assign o_in_ready  = sel ? b_in_ready  : s_in_ready;
  assign o_out_valid = sel ? b_out_valid : s_out_valid;
  assign o_out_last  = sel ? b_out_last  : s_out_last;
  assign o_out_data  = sel ? b_out_data  : s_out_data;

  conv3x3_stream #(.IMG_W(4), .IMG_H(4)) u_small (
    .clk(clk), .reset_n(reset_n),
    .cfg_we(cfg_we && !sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(s_busy),
    .in_valid(in_valid && !sel), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_last(s_out_last)
  );

  conv3x3_stream u_big (
    .clk(clk), .reset_n(reset_n),
    .cfg_we(cfg_we && sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(b_busy),
    .in_valid(in_valid && sel), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_last(b_out_last)
  );

  task automatic check(input string name, input longint got, input longint want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // y(r,c) = bias + sum k(i)*p(i) over the 3x3 neighbourhood centred at (r,c), wrapped to 32 bits
  function automatic int model_y(input int w, input int r, input int c);
    longint acc;
    int y;
    acc = longint'(mbias);
    for (int i = 0; i < 9; i++)
      acc += longint'(mk[i]) * longint'(pix[(r - 1 + i / 3) * w + (c - 1 + i % 3)]);
    y = int'(acc);
`ifdef CONV3X3_RELU_EN
    if (y < 0) y = 0;
`endif
    return y;
  endfunction

  task automatic expect_frame(input int h, input int w);
    for (int r = 1; r <= h - 2; r++)
      for (int c = 1; c <= w - 2; c++) begin
        exp_data.push_back(model_y(w, r, c));
        exp_last.push_back(r == h - 2 && c == w - 2);
      end
    got_data.delete();
    got_last.delete();
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
    cfg_addr  = addr;
    cfg_wdata = data;
    cfg_we    = 1'b1;
    @(posedge clk); #1;
    cfg_we    = 1'b0;
  endtask

  task automatic load_model_coefs();
    for (int i = 0; i < 9; i++) cfg_write(4'(i), 32'(mk[i]));
    cfg_write(4'd9, 32'(mbias));
  endtask

  task automatic set_coefs(input int k, input int b);
    for (int i = 0; i < 9; i++) mk[i] = k;
    mbias = b;
  endtask

  task automatic send_pixels(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(pix[i]);
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clk);
        acc = o_in_ready;
        @(posedge clk); #1;
      end
      if (!acc) begin
        n_vec++; n_err++;
        $display("FAIL accept_timeout: pixel %0d not accepted within 200 cycles", i);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      done = (exp_data.size() == 0) && !o_busy;
    end
    check("drain_pending", exp_data.size(), 0);
    check("busy_after_frame", o_busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic stall_ctl();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = o_out_valid;
    end
    check("t3_first_valid_seen", seen, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (!o_in_ready) stall_lo++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  endtask

  // Compare process: scoreboard order, last flag, stall hold and in_ready rule
  task automatic monitor();
    bit prev_stall;
    int prev_data;
    bit prev_last;
    prev_stall = 1'b0; prev_data = 0; prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", o_out_valid, 1);
          check("stall_data_held", o_out_data, prev_data);
          check("stall_last_held", o_out_last, prev_last);
        end
        check("in_ready_rule", o_in_ready, !(o_out_valid && !out_ready));
        if (o_out_valid && out_ready) begin
          if (exp_data.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL spurious_out: got %0d, expected no result", o_out_data);
          end else begin
            check("out_data", o_out_data, exp_data.pop_front());
            check("out_last", o_out_last, exp_last.pop_front());
          end
          got_data.push_back(o_out_data);
          got_last.push_back(o_out_last);
        end
        prev_stall = o_out_valid && !out_ready;
        prev_data  = o_out_data;
        prev_last  = o_out_last;
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1_want [4];
    t1_want = '{5, 6, 9, 10};
    fork monitor(); join_none

    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_s_out_valid", s_out_valid, 0);
    check("rst_s_busy", s_busy, 0);
    check("rst_s_in_ready", s_in_ready, 1);
    check("rst_s_out_data", s_out_data, 0);
    check("rst_b_out_last", b_out_last, 0);
    check("rst_b_busy", b_busy, 0);
    @(posedge clk); #1;

    // T1: 4x4 identity-centre kernel over pixels 0..15
    sel = 1'b0;
    set_coefs(0, 0); mk[4] = 1;
    load_model_coefs();
    for (int i = 0; i < 16; i++) pix[i] = i;
    expect_frame(4, 4);
    send_pixels(16);
    drain();
    check("t1_count", got_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_data_lit", got_data[i], t1_want[i]);
      check("t1_last_lit", got_last[i], (i == 3) ? 1 : 0);
    end

    // T3: same frame with a 5-cycle output stall
    expect_frame(4, 4);
    stall_lo = 0;
    fork
      send_pixels(16);
      stall_ctl();
    join
    drain();
    check("t3_in_ready_low_cycles", stall_lo, 5);
    check("t3_count", got_data.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_data_lit", got_data[i], t1_want[i]);

    // T4: wrap-around and negative sums
    set_coefs(32767, 0);
    load_model_coefs();
    for (int i = 0; i < 16; i++) pix[i] = 32767;
    expect_frame(4, 4);
    send_pixels(16);
    drain();
    check("t4_wrap_lit", got_data[0], 1073152009);
    set_coefs(-1, 0);
    load_model_coefs();
    for (int i = 0; i < 16; i++) pix[i] = 5;
    expect_frame(4, 4);
    send_pixels(16);
    drain();
`ifdef CONV3X3_RELU_EN
    check("t4_neg_lit", got_data[0], 0);
`else
    check("t4_neg_lit", got_data[0], -45);
`endif

    // T2: full 28x28 frame, ones kernel, bias -10, flat input of 2
    sel = 1'b1;
    @(posedge clk); #1;
    set_coefs(1, -10);
    load_model_coefs();
    for (int i = 0; i < 784; i++) pix[i] = 2;
    expect_frame(28, 28);
    send_pixels(784);
    check("t2_busy_tail", o_busy, 1);
    drain();
    check("t2_count", got_data.size(), 676);
    check("t2_data_lit", got_data[675], 8);
    check("t2_last_on_676", got_last[675], 1);
    check("t2_last_not_675", got_last[674], 0);

    // T6: k4 write while busy is dropped, then applied once idle
    expect_frame(28, 28);
    fork
      send_pixels(784);
      begin
        repeat (50) @(posedge clk); #1;
        check("t6_busy_mid", o_busy, 1);
        cfg_write(4'd4, 32'd7);
      end
    join
    drain();
    check("t6_dropped_lit", got_data[0], 8);
    mk[4] = 7;
    cfg_write(4'd4, 32'd7);
    expect_frame(28, 28);
    send_pixels(784);
    drain();
    check("t6_applied_lit", got_data[0], 20);

    // T5: reset 10 pixels into a frame, reload, rerun T2
    send_pixels(10);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_out_valid", o_out_valid, 0);
    check("t5_busy", o_busy, 0);
    exp_data.delete();
    exp_last.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    set_coefs(1, -10);
    load_model_coefs();
    expect_frame(28, 28);
    send_pixels(784);
    drain();
    check("t5_count", got_data.size(), 676);
    check("t5_data_lit", got_data[0], 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
